ex_mem_stage: RTL and testbench

Parametrised EX→MEM pipeline stage: a two-entry elastic register carrying the execute-stage result bundle (opcode, rd write-enable/address/data) with valid/ready handshaking on both sides, synchronous flush, and x0-write suppression. It sits between the execute unit and the memory stage. It replaces a plain per-cycle latch, so a stalled memory stage back-pressures execute without dropping or duplicating instructions.

---
 rtl/ex_mem_stage.sv | 149 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// Two-entry elastic register between the execute unit and the memory stage.
// Carries the execute result bundle (opcode, rd write-enable/address/data)
// with valid/ready handshaking on both sides, a synchronous flush and
// optional suppression of writes to register x0.
//
// State table
//   state    | meaning
//   ST_EMPTY | no valid entry, count 0
//   ST_ONE   | main register valid, count 1
//   ST_FULL  | main and skid registers valid, count 2
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   flush      synchronous kill of all held entries
//   in_valid   execute offers a bundle
//   in_ready   stage can accept this cycle (registered)
//   opcode_i   opcode from execute
//   rd_we_i    writeback enable from execute
//   rd_addr_i  destination register
//   rd_data_i  result data
//   out_valid  head entry valid toward the memory stage
//   out_ready  memory stage accepts head
//   opcode_o   head opcode
//   rd_we      head write enable, gated by out_valid
//   rd_addr    head destination
//   rd_data    head data
//   count      occupancy, 0..2
// ----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int OP_W      = 7,
    parameter int RA_W      = 5,
    parameter int XLEN      = 32,
    parameter int ZERO_KILL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            rd_we_i,
    input  logic [RA_W-1:0] rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] opcode_o,
    output logic            rd_we,
    output logic [RA_W-1:0] rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [1:0]      count
);

    // Bundle layout: {opcode, we, addr, data}
    localparam int BW = OP_W + 1 + RA_W + XLEN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   main_q, main_d;
    logic [BW-1:0]   skid_q, skid_d;
    logic            in_ready_q, in_ready_d;

    logic            push;
    logic            pop;
    logic            cap_we;
    logic [BW-1:0]   cap_bundle;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // x0 suppression is applied once, at capture, so the stored bundle is
    // never modified afterwards.
    assign cap_we     = rd_we_i & ((ZERO_KILL == 0) || (rd_addr_i != '0));
    assign cap_bundle = {opcode_i, cap_we, rd_addr_i, rd_data_i};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Held entries and any same-cycle push are dropped; a same-cycle
            // pop has already been seen by the consumer.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = cap_bundle;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = cap_bundle;
                    end else if (push) begin
                        skid_d  = cap_bundle;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Payload outputs show the main register and hold when out_valid is low.
    assign opcode_o = main_q[BW-1 -: OP_W];
    assign rd_we    = main_q[XLEN + RA_W] & out_valid;
    assign rd_addr  = main_q[XLEN +: RA_W];
    assign rd_data  = main_q[XLEN-1:0];
    assign count    = state_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic        rd_we_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic [31:0] rd_data_i = '0;

    logic        in_ready, out_valid, rd_we;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  count;

    logic        nk_in_ready, nk_out_valid, nk_rd_we;
    logic [6:0]  nk_opcode_o;
    logic [4:0]  nk_rd_addr;
    logic [31:0] nk_rd_data;
    logic [1:0]  nk_count;

    logic        w_flush = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_out_ready = 1'b0;
    logic [7:0]  w_opcode_i = '0;
    logic        w_rd_we_i = 1'b0;
    logic [5:0]  w_rd_addr_i = '0;
    logic [63:0] w_rd_data_i = '0;
    logic        w_in_ready, w_out_valid, w_rd_we;
    logic [7:0]  w_opcode_o;
    logic [5:0]  w_rd_addr;
    logic [63:0] w_rd_data;
    logic [1:0]  w_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_i(opcode_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .out_valid(out_valid), .out_ready(out_ready), .opcode_o(opcode_o), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count)
    );

    ex_mem_stage #(.ZERO_KILL(0)) dut_nk (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nk_in_ready),
        .opcode_i(opcode_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .out_valid(nk_out_valid), .out_ready(out_ready), .opcode_o(nk_opcode_o), .rd_we(nk_rd_we),
        .rd_addr(nk_rd_addr), .rd_data(nk_rd_data), .count(nk_count)
    );

    ex_mem_stage #(.OP_W(8), .RA_W(6), .XLEN(64)) dut_w (
        .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .opcode_i(w_opcode_i), .rd_we_i(w_rd_we_i), .rd_addr_i(w_rd_addr_i), .rd_data_i(w_rd_data_i),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .opcode_o(w_opcode_o), .rd_we(w_rd_we),
        .rd_addr(w_rd_addr), .rd_data(w_rd_data), .count(w_count)
    );

    // Reference model: an ordered queue of at most two bundles, plus the
    // bundle most recently shown at the head (outputs hold it when empty).
    typedef struct {
        logic [6:0]  op;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } bundle_t;

    bundle_t q[$];
    bundle_t shown;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        shown = '{op: '0, we: 1'b0, addr: '0, data: '0};
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n < 2));
        chk("rd_we", 64'(rd_we), 64'((n > 0) && shown.we));
        chk("opcode_o", 64'(opcode_o), 64'(shown.op));
        chk("rd_addr", 64'(rd_addr), 64'(shown.addr));
        chk("rd_data", 64'(rd_data), 64'(shown.data));
    endtask

    // Called just after a falling edge: drive, clock, update model, check.
    task automatic step(input logic v, input logic r, input logic f,
                        input logic [6:0] op, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, output logic pushed);
        logic rdy, pop;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        opcode_i  = op;
        rd_we_i   = we;
        rd_addr_i = addr;
        rd_data_i = data;
        @(posedge clk);
        rdy    = (q.size() < 2);
        pop    = (q.size() > 0) && r;
        pushed = v && rdy && !f;
        if (f) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (pushed) q.push_back('{op: op, we: we && (addr != 0), addr: addr, data: data});
        end
        if (q.size() > 0) shown = q[0];
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic pushed;
        int   tries;

        model_reset();
        #12 rst = 1'b1;
        @(negedge clk);
        check_outputs();

        // Streaming with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 7'(i), 1'b1, 5'(i), 32'h100 + 32'(i), pushed);
            chk("stream_data", 64'(rd_data), 64'(32'h100 + 32'(i)));
            chk("stream_count", 64'(count), 64'd1);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);

        // Back-pressure: A held, B in skid, C refused until room frees up
        step(1'b1, 1'b0, 1'b0, 7'h0A, 1'b1, 5'd3, 32'hAAAA, pushed);
        step(1'b1, 1'b0, 1'b0, 7'h0B, 1'b1, 5'd4, 32'hBBBB, pushed);
        chk("bp_full_count", 64'(count), 64'd2);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, 1'b0, 7'h0C, 1'b1, 5'd5, 32'hCCCC, pushed);
        chk("bp_hold_a", 64'(rd_data), 64'hAAAA);
        tries = 0;
        do begin
            step(1'b1, 1'b1, 1'b0, 7'h0C, 1'b1, 5'd5, 32'hCCCC, pushed);
            tries++;
        end while (!pushed && tries < 6);
        chk("bp_c_accept", 64'(pushed), 64'd1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);
        chk("bp_c_out", 64'(rd_data), 64'hCCCC);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);

        // Flush while FULL, with a simultaneous push of 0xDEAD
        step(1'b1, 1'b0, 1'b0, 7'h11, 1'b1, 5'd6, 32'h1111, pushed);
        step(1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 5'd7, 32'h2222, pushed);
        step(1'b1, 1'b0, 1'b1, 7'h33, 1'b1, 5'd8, 32'hDEAD, pushed);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);
            chk("flush_no_dead", 64'(rd_data == 32'hDEAD), 64'd0);
        end

        // x0 write suppression, with and without ZERO_KILL
        step(1'b1, 1'b0, 1'b0, 7'h13, 1'b1, 5'd0, 32'h55, pushed);
        chk("x0_kill_valid", 64'(out_valid), 64'd1);
        chk("x0_kill_we", 64'(rd_we), 64'd0);
        chk("x0_keep_valid", 64'(nk_out_valid), 64'd1);
        chk("x0_keep_we", 64'(nk_rd_we), 64'd1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);

        // Async reset between edges while FULL
        step(1'b1, 1'b0, 1'b0, 7'h44, 1'b1, 5'd9, 32'h4444, pushed);
        step(1'b1, 1'b0, 1'b0, 7'h55, 1'b1, 5'd10, 32'h5555, pushed);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        #1 rst = 1'b1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        step(1'b1, 1'b0, 1'b0, 7'h66, 1'b1, 5'd11, 32'h6666, pushed);
        chk("rst_first_push", 64'(rd_data), 64'h6666);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, pushed);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, 7'($urandom), 1'($urandom), a,
                 32'($urandom), pushed);
        end

        // Wide parameter set
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_opcode_i  = 8'hA5;
        w_rd_we_i   = 1'b1;
        w_rd_addr_i = 6'h2A;
        w_rd_data_i = 64'hFFFF_0000_1234_5678;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        chk("w_valid", 64'(w_out_valid), 64'd1);
        chk("w_data", w_rd_data, 64'hFFFF_0000_1234_5678);
        chk("w_addr", 64'(w_rd_addr), 64'h2A);
        chk("w_opcode", 64'(w_opcode_o), 64'hA5);
        chk("w_we", 64'(w_rd_we), 64'd1);
        @(negedge clk);
        chk("w_drained", 64'(w_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
